// File: rtl/instrumented_adder_sklansky_wrap.sv
// Caravel user-project wrapper: 32-bit Sklansky prefix adder with a ring-oscillator style delay loop.
// Optional toggle counter is built only when RING_COUNTER_EN is defined.
module instrumented_adder_sklansky_wrap (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        active,
    input  logic [31:0] la1_data_in,
    input  logic [31:0] la2_data_in,
    input  logic [31:0] la3_data_in,
    input  logic [31:0] la1_oenb,
    input  logic [31:0] la2_oenb,
    input  logic [31:0] la3_oenb,
    output logic [31:0] la1_data_out,
    output logic [31:0] la2_data_out,
    output logic [31:0] la3_data_out,
    input  logic [37:0] io_in,
    output logic [37:0] io_out,
    output logic [37:0] io_oeb
);

    localparam logic [37:0] OEB_ACTIVE = ~((38'd1 << 8) | (38'd1 << 10));

    logic [31:0] a_input;
    logic [31:0] b_input;
    logic [31:0] a_input_ring_bit_b;
    logic [31:0] a_input_ext_bit_b;
    logic [31:0] s_output_bit_b;
    logic        chain_out;
    logic [31:0] count;

    logic [31:0] a_eff;
    logic [31:0] gen0;
    logic [31:0] prop0;
    logic [31:0] g_cur;
    logic [31:0] p_cur;
    logic [31:0] g_nxt;
    logic [31:0] p_nxt;
    logic [4:0]  j_idx;
    logic [31:0] sum;
    logic        cout;
    logic        chain_next;
    logic [37:0] io_drive;

    // Masks are active-low; a ring-selected bit wins over an ext-selected bit.
    assign a_eff = (~a_input_ring_bit_b & {32{~chain_out}})
                 | (a_input_ring_bit_b & ~a_input_ext_bit_b & {32{io_in[9]}})
                 | (a_input_ring_bit_b & a_input_ext_bit_b & a_input);

    // Sklansky tree: at level lvl every bit whose index has bit lvl set combines with
    // the topmost bit of the lower half of its 2^(lvl+1) block.
    always_comb begin
        gen0  = a_eff & b_input;
        prop0 = a_eff ^ b_input;
        g_cur = gen0;
        p_cur = prop0;
        g_nxt = gen0;
        p_nxt = prop0;
        j_idx = '0;
        for (int lvl = 0; lvl < 5; lvl++) begin
            g_nxt = g_cur;
            p_nxt = p_cur;
            for (int i = 0; i < 32; i++) begin
                if (((i >> lvl) & 1) != 0) begin
                    j_idx = 5'(((i >> lvl) << lvl) - 1);
                    g_nxt[i[4:0]] = g_cur[i[4:0]] | (p_cur[i[4:0]] & g_cur[j_idx]);
                    p_nxt[i[4:0]] = p_cur[i[4:0]] & p_cur[j_idx];
                end
            end
            g_cur = g_nxt;
            p_cur = p_nxt;
        end
        sum  = prop0 ^ {g_cur[30:0], 1'b0};
        cout = g_cur[31];
    end

    assign chain_next = ^(sum & ~s_output_bit_b);

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            a_input            <= '0;
            b_input            <= '0;
            a_input_ring_bit_b <= '1;
            a_input_ext_bit_b  <= '1;
            s_output_bit_b     <= '1;
            chain_out          <= 1'b0;
        end else begin
            if (la3_data_in[0]) a_input            <= la1_data_in;
            if (la3_data_in[1]) b_input            <= la2_data_in;
            if (la3_data_in[2]) a_input_ring_bit_b <= la1_data_in;
            if (la3_data_in[3]) a_input_ext_bit_b  <= la2_data_in;
            if (la3_data_in[4]) s_output_bit_b     <= la1_data_in;
            chain_out <= chain_next;
        end
    end

`ifdef RING_COUNTER_EN
    // Counts on the same edge that flips chain_out; clear overrides increment.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            count <= '0;
        end else if (la3_data_in[6]) begin
            count <= '0;
        end else if (la3_data_in[5] && (chain_next != chain_out)) begin
            count <= count + 32'd1;
        end
    end

    logic unused_inputs;
    assign unused_inputs = ^{la1_oenb, la2_oenb, la3_oenb, io_in[37:10], io_in[8:0],
                             la3_data_in[31:7]};
`else
    assign count = '0;

    logic unused_inputs;
    assign unused_inputs = ^{la1_oenb, la2_oenb, la3_oenb, io_in[37:10], io_in[8:0],
                             la3_data_in[31:5]};
`endif

    always_comb begin
        io_drive     = '0;
        io_drive[8]  = chain_out;
        io_drive[10] = cout;
    end

    // Harness sharing: when not selected, drive nothing but keep internal state running.
    assign la1_data_out = active ? sum : '0;
    assign la2_data_out = active ? count : '0;
    assign la3_data_out = active ? {30'b0, chain_out, cout} : '0;
    assign io_out       = active ? io_drive : '0;
    assign io_oeb       = active ? OEB_ACTIVE : '1;

endmodule

// File: tb/tb_instrumented_adder_sklansky_wrap.sv
// Directed self-checking bench for instrumented_adder_sklansky_wrap (works with or without RING_COUNTER_EN).
module tb_instrumented_adder_sklansky_wrap;

`ifdef RING_COUNTER_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    localparam logic [37:0] EXP_OEB = 38'h3F_FFFF_FAFF;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_n = 1'b1;
    logic        active = 1'b1;
    logic [31:0] la1_data_in = '0;
    logic [31:0] la2_data_in = '0;
    logic [31:0] la3_data_in = '0;
    logic [31:0] la1_oenb = '1;
    logic [31:0] la2_oenb = '1;
    logic [31:0] la3_oenb = '1;
    logic [37:0] io_in = '0;
    logic [31:0] la1_data_out;
    logic [31:0] la2_data_out;
    logic [31:0] la3_data_out;
    logic [37:0] io_out;
    logic [37:0] io_oeb;

    int assert_cnt = 0;
    int fail_cnt = 0;

    instrumented_adder_sklansky_wrap dut (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_n     (wb_rst_n),
        .active       (active),
        .la1_data_in  (la1_data_in),
        .la2_data_in  (la2_data_in),
        .la3_data_in  (la3_data_in),
        .la1_oenb     (la1_oenb),
        .la2_oenb     (la2_oenb),
        .la3_oenb     (la3_oenb),
        .la1_data_out (la1_data_out),
        .la2_data_out (la2_data_out),
        .la3_data_out (la3_data_out),
        .io_in        (io_in),
        .io_out       (io_out),
        .io_oeb       (io_oeb)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Strobe for exactly one rising edge, then return on the following falling edge.
    task automatic apply_stimulus(input logic [31:0] ctrl, input logic [31:0] d1, input logic [31:0] d2);
        @(negedge wb_clk_i);
        la3_data_in = ctrl;
        la1_data_in = d1;
        la2_data_in = d2;
        @(negedge wb_clk_i);
        la3_data_in = '0;
    endtask

    task automatic test_reset;
        #1 wb_rst_n = 1'b0;
        #3;
        assert_cnt++;
        if (la1_data_out !== 32'h0) begin
            fail_cnt++; $display("[TB] FAIL reset_sum: got %h expected %h", la1_data_out, 32'h0);
        end
        assert_cnt++;
        if (la2_data_out !== 32'h0) begin
            fail_cnt++; $display("[TB] FAIL reset_count: got %h expected %h", la2_data_out, 32'h0);
        end
        assert_cnt++;
        if (la3_data_out !== 32'h0) begin
            fail_cnt++; $display("[TB] FAIL reset_status: got %h expected %h", la3_data_out, 32'h0);
        end
        assert_cnt++;
        if (io_oeb !== EXP_OEB) begin
            fail_cnt++; $display("[TB] FAIL reset_oeb: got %h expected %h", io_oeb, EXP_OEB);
        end
        assert_cnt++;
        if (io_out !== 38'h0) begin
            fail_cnt++; $display("[TB] FAIL reset_io_out: got %h expected %h", io_out, 38'h0);
        end
        @(negedge wb_clk_i);
        wb_rst_n = 1'b1;
    endtask

    task automatic test_add;
        apply_stimulus(32'h3, 32'hFFFF_FFFF, 32'h0000_0001);
        assert_cnt++;
        if (la1_data_out !== 32'h0) begin
            fail_cnt++; $display("[TB] FAIL add_wrap_sum: got %h expected %h", la1_data_out, 32'h0);
        end
        assert_cnt++;
        if (la3_data_out !== 32'h1) begin
            fail_cnt++; $display("[TB] FAIL add_wrap_cout: got %h expected %h", la3_data_out, 32'h1);
        end
        assert_cnt++;
        if (io_out !== 38'h400) begin
            fail_cnt++; $display("[TB] FAIL add_wrap_io: got %h expected %h", io_out, 38'h400);
        end
        apply_stimulus(32'h3, 32'h1234_5678, 32'h1111_1111);
        assert_cnt++;
        if (la1_data_out !== 32'h2345_6789) begin
            fail_cnt++; $display("[TB] FAIL add_plain_sum: got %h expected %h", la1_data_out, 32'h2345_6789);
        end
        assert_cnt++;
        if (la3_data_out !== 32'h0) begin
            fail_cnt++; $display("[TB] FAIL add_plain_cout: got %h expected %h", la3_data_out, 32'h0);
        end
        apply_stimulus(32'h3, 32'h0F0F_0F0F, 32'h00F0_F0F1);
        assert_cnt++;
        if (la1_data_out !== 32'h1000_0000) begin
            fail_cnt++; $display("[TB] FAIL add_ripple_sum: got %h expected %h", la1_data_out, 32'h1000_0000);
        end
    endtask

    task automatic test_inactive;
        @(negedge wb_clk_i);
        active = 1'b0;
        #1;
        assert_cnt++;
        if ({la1_data_out, la2_data_out, la3_data_out} !== 96'h0) begin
            fail_cnt++; $display("[TB] FAIL inactive_la: got %h expected %h",
                                 {la1_data_out, la2_data_out, la3_data_out}, 96'h0);
        end
        assert_cnt++;
        if (io_out !== 38'h0) begin
            fail_cnt++; $display("[TB] FAIL inactive_io_out: got %h expected %h", io_out, 38'h0);
        end
        assert_cnt++;
        if (io_oeb !== '1) begin
            fail_cnt++; $display("[TB] FAIL inactive_oeb: got %h expected %h", io_oeb, 38'h3F_FFFF_FFFF);
        end
        repeat (2) @(negedge wb_clk_i);
        active = 1'b1;
        #1;
        assert_cnt++;
        if (la1_data_out !== 32'h1000_0000) begin
            fail_cnt++; $display("[TB] FAIL reactive_sum: got %h expected %h", la1_data_out, 32'h1000_0000);
        end
    endtask

    task automatic test_ext;
        apply_stimulus(32'h3, 32'h0, 32'h0);
        apply_stimulus(32'h8, 32'h0, 32'hFFFF_FFFE);
        io_in[9] = 1'b1;
        #1;
        assert_cnt++;
        if (la1_data_out !== 32'h1) begin
            fail_cnt++; $display("[TB] FAIL ext_high: got %h expected %h", la1_data_out, 32'h1);
        end
        io_in[9] = 1'b0;
        #1;
        assert_cnt++;
        if (la1_data_out !== 32'h0) begin
            fail_cnt++; $display("[TB] FAIL ext_low: got %h expected %h", la1_data_out, 32'h0);
        end
        apply_stimulus(32'h8, 32'h0, 32'hFFFF_FFFF);
    endtask

    task automatic test_ring;
        logic [31:0] exp_cnt;
        @(negedge wb_clk_i);
        la1_data_in = 32'hFFFF_FFFE;
        la3_data_in = 32'h34;
        @(negedge wb_clk_i);
        la3_data_in = 32'h20;
        assert_cnt++;
        if ({la3_data_out[1], la1_data_out, la2_data_out} !== {1'b0, 32'h1, 32'h0}) begin
            fail_cnt++; $display("[TB] FAIL ring_start: got %h expected %h",
                                 {la3_data_out[1], la1_data_out, la2_data_out}, {1'b0, 32'h1, 32'h0});
        end
        for (int k = 1; k <= 10; k++) begin
            @(negedge wb_clk_i);
            exp_cnt = CNT_EN ? 32'(k) : 32'h0;
            assert_cnt++;
            if (la3_data_out[1] !== 1'(k & 1)) begin
                fail_cnt++; $display("[TB] FAIL ring_chain_%0d: got %b expected %b", k, la3_data_out[1], 1'(k & 1));
            end
            assert_cnt++;
            if (la2_data_out !== exp_cnt) begin
                fail_cnt++; $display("[TB] FAIL ring_count_%0d: got %h expected %h", k, la2_data_out, exp_cnt);
            end
        end
        la3_data_in = 32'h40;
        @(negedge wb_clk_i);
        la3_data_in = 32'h0;
        assert_cnt++;
        if ({la3_data_out[1], la2_data_out} !== {1'b1, 32'h0}) begin
            fail_cnt++; $display("[TB] FAIL ring_clear: got %h expected %h", {la3_data_out[1], la2_data_out}, {1'b1, 32'h0});
        end
    endtask

    task automatic test_async_reset;
        logic [31:0] exp_cnt;
        la3_data_in = 32'h20;
        repeat (2) @(negedge wb_clk_i);
        la3_data_in = 32'h0;
        exp_cnt = CNT_EN ? 32'h2 : 32'h0;
        assert_cnt++;
        if ({la3_data_out[1], la2_data_out} !== {1'b1, exp_cnt}) begin
            fail_cnt++; $display("[TB] FAIL pre_reset_ring: got %h expected %h", {la3_data_out[1], la2_data_out}, {1'b1, exp_cnt});
        end
        #2 wb_rst_n = 1'b0;
        #1;
        assert_cnt++;
        if ({la1_data_out, la2_data_out, la3_data_out} !== 96'h0) begin
            fail_cnt++; $display("[TB] FAIL async_reset_outputs: got %h expected %h",
                                 {la1_data_out, la2_data_out, la3_data_out}, 96'h0);
        end
        @(negedge wb_clk_i);
        wb_rst_n = 1'b1;
        io_in[9] = 1'b1;
        @(negedge wb_clk_i);
        assert_cnt++;
        if ({la1_data_out, la3_data_out} !== 64'h0) begin
            fail_cnt++; $display("[TB] FAIL masks_disabled: got %h expected %h", {la1_data_out, la3_data_out}, 64'h0);
        end
    endtask

    initial begin
        $display("[TB] starting, counter build = %0d", CNT_EN);
        test_reset();
        test_add();
        test_inactive();
        test_ext();
        test_ring();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
